ysyx_210544_exe_ctrl: RTL

//   Execute-stage sequencer sitting between the ID stage and the combinational

---
 rtl/ysyx_210544_exe_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_210544_exe_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_210544_exe_ctrl
//
// Execute-stage sequencer between the ID stage and the combinational execute
// unit. One instruction is latched per i_valid/o_ready handshake. The execute
// unit's enable is then driven for exactly one cycle (short op) or for
// LONG_OP_CYCLES consecutive cycles (long op such as mul/div). The result is
// captured on the last enable cycle and offered to the commit side with an
// o_valid/i_ready handshake. A taken jump produces a one-cycle o_redirect pulse.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   i_valid / o_ready                instruction handshake from ID
//   i_inst_type/opcode, i_long_op    decoded instruction, latched on accept
//   i_op1/i_op2/i_op3                operands, latched on accept
//   i_flush                          aborts the held instruction, wins over all
//   o_exe_ena, o_exe_type/opcode,
//   o_exe_op1/2/3                    drive of the combinational execute unit
//   i_exe_ack_req, i_exe_rd_wdata,
//   i_exe_pc_jmp/jmpaddr,
//   i_exe_skip_cmt                   execute unit results
//   o_ack                            ack to execute unit, first DONE cycle
//   o_valid / i_ready                result handshake to commit side
//   o_rd_wdata, o_skip_cmt           captured result
//   o_redirect, o_redirect_addr      one-cycle PC redirect and its target
//   o_busy                           controller not idle
// ----------------------------------------------------------------------------
module ysyx_210544_exe_ctrl #(
  parameter int LONG_OP_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_inst_type,
  input  logic [7:0]  i_inst_opcode,
  input  logic        i_long_op,
  input  logic [63:0] i_op1,
  input  logic [63:0] i_op2,
  input  logic [63:0] i_op3,
  input  logic        i_flush,
  output logic        o_exe_ena,
  output logic [4:0]  o_exe_type,
  output logic [7:0]  o_exe_opcode,
  output logic [63:0] o_exe_op1,
  output logic [63:0] o_exe_op2,
  output logic [63:0] o_exe_op3,
  input  logic        i_exe_ack_req,
  input  logic [63:0] i_exe_rd_wdata,
  input  logic        i_exe_pc_jmp,
  input  logic [63:0] i_exe_pc_jmpaddr,
  input  logic        i_exe_skip_cmt,
  output logic        o_ack,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_rd_wdata,
  output logic        o_skip_cmt,
  output logic        o_redirect,
  output logic [63:0] o_redirect_addr,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_LONG = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // EXEC supplies the first enable cycle; LONG counts the remaining ones
  // down to zero, so it starts two below the total.
  localparam logic [5:0] LONG_CNT_INIT = 6'(LONG_OP_CYCLES - 2);

  generate
    if (LONG_OP_CYCLES < 2 || LONG_OP_CYCLES > 63) begin : g_bad_long_op_cycles
      $error("LONG_OP_CYCLES must lie in 2..63");
    end
  endgenerate

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        first_q;
  logic        long_q;
  logic [4:0]  type_q;
  logic [7:0]  opcode_q;
  logic [63:0] op1_q, op2_q, op3_q;
  logic [63:0] rd_wdata_q;
  logic        skip_q;
  logic        jmp_q;
  logic [63:0] jmpaddr_q;

  logic ready;
  logic accept;
  logic capture;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    ready   = !i_flush && (state_q == S_IDLE || (state_q == S_DONE && i_ready));
    accept  = i_valid && ready;
    // Result is valid on the last enable cycle of the instruction.
    capture = !i_flush && ((state_q == S_EXEC && !long_q) ||
                           (state_q == S_LONG && cnt_q == 6'd0));
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_EXEC;
        S_EXEC: begin
          if (long_q) begin
            state_d = S_LONG;
            cnt_d   = LONG_CNT_INIT;
          end else begin
            state_d = S_DONE;
          end
        end
        S_LONG: begin
          if (cnt_q == 6'd0) state_d = S_DONE;
          else               cnt_d   = cnt_q - 6'd1;
        end
        S_DONE: begin
          if (accept)       state_d = S_EXEC;
          else if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, because all outputs
      // (including captured data and latched operands) must read 0 after reset.
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      first_q    <= 1'b0;
      long_q     <= 1'b0;
      type_q     <= '0;
      opcode_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      op3_q      <= '0;
      rd_wdata_q <= '0;
      skip_q     <= 1'b0;
      jmp_q      <= 1'b0;
      jmpaddr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Marks the first DONE cycle; redirect and ack fire only there.
      first_q <= (state_d == S_DONE) && (state_q != S_DONE);
      if (accept) begin
        long_q   <= i_long_op;
        type_q   <= i_inst_type;
        opcode_q <= i_inst_opcode;
        op1_q    <= i_op1;
        op2_q    <= i_op2;
        op3_q    <= i_op3;
      end
      if (capture) begin
        rd_wdata_q <= i_exe_rd_wdata;
        skip_q     <= i_exe_skip_cmt;
        jmp_q      <= i_exe_pc_jmp;
        jmpaddr_q  <= i_exe_pc_jmpaddr;
      end
      // A flushed instruction must not leave a redirect behind.
      if (i_flush) jmp_q <= 1'b0;
    end
  end

  assign o_ready         = ready;
  assign o_exe_ena       = (state_q == S_EXEC || state_q == S_LONG) && !i_flush;
  assign o_exe_type      = type_q;
  assign o_exe_opcode    = opcode_q;
  assign o_exe_op1       = op1_q;
  assign o_exe_op2       = op2_q;
  assign o_exe_op3       = op3_q;
  assign o_valid         = (state_q == S_DONE) && !i_flush;
  assign o_ack           = (state_q == S_DONE) && first_q && !i_flush;
  assign o_redirect      = (state_q == S_DONE) && first_q && jmp_q && !i_flush;
  assign o_redirect_addr = jmpaddr_q;
  assign o_rd_wdata      = rd_wdata_q;
  assign o_skip_cmt      = skip_q;
  assign o_busy          = (state_q != S_IDLE);

  // The execute unit must be requesting an ack when the result is first offered.
  ack_req_in_done: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_DONE && first_q) |-> i_exe_ack_req)
    else $error("i_exe_ack_req low in first DONE cycle");

endmodule
